// File: rtl/bw_seq_mult.sv
// Iterative Baugh-Wooley multiplier: one partial-product row per clock into a 2*WIDTH accumulator.
// Signed or unsigned per operation, with valid/ready handshakes on the operand and result sides.
module bw_seq_mult #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 is_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   p,
   output logic                 busy
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_ROW = CW'(WIDTH - 1);
   localparam logic [PW-1:0] BW_CORR  = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_n;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic              sgn_q;
   logic [CW-1:0]     cnt;
   logic [PW-1:0]     acc;
   logic [PW-1:0]     acc_n;
   logic [WIDTH-1:0]  row;
   logic              accept;
   logic              last_row;

   assign accept   = (state == IDLE) && in_valid;
   assign last_row = (cnt == LAST_ROW);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (in_valid)  state_n = CALC;
         CALC:    if (last_row)  state_n = DONE;
         DONE:    if (out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Row i: a & b[i]; in signed mode, bits with exactly one index at the MSB are inverted
   always_comb begin
      row = '0;
      for (int unsigned j = 0; j < WIDTH; j++) begin
         row[j] = a_q[j] & b_q[cnt];
         if (sgn_q && ((j == WIDTH - 1) != last_row)) begin
            row[j] = ~row[j];
         end
      end
   end

   assign acc_n = acc + (PW'(row) << cnt);

   // Operand capture, row accumulation and result latch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         sgn_q <= 1'b0;
         cnt   <= '0;
         acc   <= '0;
         p     <= '0;
      end else begin
         if (accept) begin
            a_q   <= a;
            b_q   <= b;
            sgn_q <= is_signed;
            cnt   <= '0;
            acc   <= is_signed ? BW_CORR : '0;
         end else if (state == CALC) begin
            acc <= acc_n;
            cnt <= cnt + CW'(1);
            if (last_row) begin
               p <= acc_n;
            end
         end
      end
   end

   // Handshake/status outputs registered from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         in_ready  <= (state_n == IDLE);
         out_valid <= (state_n == DONE);
         busy      <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_bw_seq_mult.sv
// Bench for bw_seq_mult: directed WIDTH=4 scenarios plus randomized WIDTH=8 traffic
// checked against an integer-arithmetic product model.
module tb_bw_seq_mult;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        w4_in_valid, w4_in_ready, w4_is_signed, w4_out_valid, w4_out_ready, w4_busy;
   logic [3:0]  w4_a, w4_b;
   logic [7:0]  w4_p;

   logic        w8_in_valid, w8_in_ready, w8_is_signed, w8_out_valid, w8_out_ready, w8_busy;
   logic [7:0]  w8_a, w8_b;
   logic [15:0] w8_p;

   int checks = 0;
   int errors = 0;

   bw_seq_mult #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst),
      .in_valid(w4_in_valid), .in_ready(w4_in_ready),
      .a(w4_a), .b(w4_b), .is_signed(w4_is_signed),
      .out_valid(w4_out_valid), .out_ready(w4_out_ready),
      .p(w4_p), .busy(w4_busy)
   );

   bw_seq_mult #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst),
      .in_valid(w8_in_valid), .in_ready(w8_in_ready),
      .a(w8_a), .b(w8_b), .is_signed(w8_is_signed),
      .out_valid(w8_out_valid), .out_ready(w8_out_ready),
      .p(w8_p), .busy(w8_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Exact product of w-bit operands, reduced to 2w bits
   function automatic logic [31:0] ref_mul(input int w, input logic [31:0] x, input logic [31:0] y,
                                           input logic s);
      longint xv, yv, pr;
      xv = longint'(x);
      yv = longint'(y);
      if (s && x[w-1]) xv = xv - (longint'(1) << w);
      if (s && y[w-1]) yv = yv - (longint'(1) << w);
      pr = (xv * yv) & ((longint'(1) << (2 * w)) - 1);
      return 32'(pr);
   endfunction

   task automatic start4(input logic [3:0] av, input logic [3:0] bv, input logic s);
      @(negedge clk);
      w4_a = av; w4_b = bv; w4_is_signed = s; w4_in_valid = 1'b1;
      @(posedge clk); #1;
      w4_in_valid = 1'b0;
   endtask

   task automatic wait_done4(input string tag, input logic [7:0] exp);
      int lat = 0;
      logic busy_all = 1'b1;
      while (!w4_out_valid && lat < 20) begin
         @(negedge clk);
         w4_a = 4'($urandom); w4_b = 4'($urandom); w4_is_signed = 1'($urandom);
         @(posedge clk); #1;
         lat++;
         busy_all &= w4_busy;
      end
      check({tag, " latency"}, 32'(lat), 32'd4);
      check({tag, " busy"}, 32'(busy_all), 32'd1);
      check({tag, " p"}, 32'(w4_p), 32'(exp));
   endtask

   task automatic consume4(input string tag);
      @(negedge clk);
      w4_in_valid = 1'b0; w4_out_ready = 1'b1;
      @(posedge clk); #1;
      w4_out_ready = 1'b0;
      check({tag, " out_valid after consume"}, 32'(w4_out_valid), 32'd0);
      check({tag, " in_ready after consume"}, 32'(w4_in_ready), 32'd1);
   endtask

   task automatic op8(input int n);
      logic [7:0] av, bv;
      logic       s;
      int         lat = 0;
      int         stall;
      logic [15:0] exp;
      av = 8'($urandom); bv = 8'($urandom); s = 1'($urandom);
      if ($urandom_range(0, 7) == 0) av = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'hFF;
      if ($urandom_range(0, 7) == 0) bv = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h7F;
      exp = 16'(ref_mul(8, 32'(av), 32'(bv), s));
      @(negedge clk);
      w8_a = av; w8_b = bv; w8_is_signed = s; w8_in_valid = 1'b1;
      @(posedge clk); #1;
      while (!w8_out_valid && lat < 40) begin
         @(negedge clk);
         w8_a = 8'($urandom); w8_b = 8'($urandom); w8_is_signed = 1'($urandom);
         w8_in_valid = 1'($urandom);
         @(posedge clk); #1;
         lat++;
      end
      check($sformatf("w8 op%0d latency", n), 32'(lat), 32'd8);
      stall = $urandom_range(0, 3);
      repeat (stall) begin
         @(negedge clk);
         w8_in_valid = 1'($urandom); w8_a = 8'($urandom); w8_b = 8'($urandom);
      end
      #1;
      check($sformatf("w8 op%0d a=%0h b=%0h s=%0d p", n, av, bv, s), 32'(w8_p), 32'(exp));
      @(negedge clk);
      w8_in_valid = 1'b0; w8_out_ready = 1'b1;
      @(posedge clk); #1;
      w8_out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      w4_in_valid = 1'b0; w4_a = '0; w4_b = '0; w4_is_signed = 1'b0; w4_out_ready = 1'b0;
      w8_in_valid = 1'b0; w8_a = '0; w8_b = '0; w8_is_signed = 1'b0; w8_out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset in_ready", 32'(w4_in_ready), 32'd1);
      check("reset out_valid", 32'(w4_out_valid), 32'd0);
      check("reset busy", 32'(w4_busy), 32'd0);
      check("reset p", 32'(w4_p), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Most-negative squared, with accept-time handshake state
      start4(4'h8, 4'h8, 1'b1);
      check("t1 in_ready after accept", 32'(w4_in_ready), 32'd0);
      check("t1 busy after accept", 32'(w4_busy), 32'd1);
      wait_done4("t1 8x8 signed", 8'h40);
      check("t1 in_ready in done", 32'(w4_in_ready), 32'd0);
      consume4("t1");

      start4(4'h8, 4'h7, 1'b1);
      wait_done4("t2 8x7 signed", 8'hC8);
      consume4("t2a");
      start4(4'hF, 4'hF, 1'b1);
      wait_done4("t2 FxF signed", 8'h01);
      consume4("t2b");

      start4(4'hF, 4'hF, 1'b0);
      wait_done4("t3 FxF unsigned", 8'hE1);
      consume4("t3");

      // out_ready while idle must do nothing
      @(negedge clk);
      w4_out_ready = 1'b1;
      @(posedge clk); #1;
      w4_out_ready = 1'b0;
      check("idle out_ready out_valid", 32'(w4_out_valid), 32'd0);
      check("idle out_ready in_ready", 32'(w4_in_ready), 32'd1);
      check("idle out_ready busy", 32'(w4_busy), 32'd0);

      // Stall in DONE with operand noise, then back-to-back accept
      start4(4'h5, 4'h6, 1'b1);
      wait_done4("t4 5x6 signed", 8'h1E);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         w4_in_valid = ~w4_in_valid; w4_a = 4'($urandom); w4_b = 4'($urandom);
         @(posedge clk); #1;
         check($sformatf("t4 stall%0d p", k), 32'(w4_p), 32'h1E);
         check($sformatf("t4 stall%0d out_valid", k), 32'(w4_out_valid), 32'd1);
         check($sformatf("t4 stall%0d in_ready", k), 32'(w4_in_ready), 32'd0);
      end
      @(negedge clk);
      w4_in_valid = 1'b1; w4_a = 4'h2; w4_b = 4'h3; w4_is_signed = 1'b0; w4_out_ready = 1'b1;
      @(posedge clk); #1;
      w4_out_ready = 1'b0;
      check("t4 consume out_valid", 32'(w4_out_valid), 32'd0);
      check("t4 consume in_ready", 32'(w4_in_ready), 32'd1);
      check("t4 consume busy", 32'(w4_busy), 32'd0);
      @(posedge clk); #1;
      w4_in_valid = 1'b0;
      check("t4 next accept in_ready", 32'(w4_in_ready), 32'd0);
      check("t4 next accept busy", 32'(w4_busy), 32'd1);
      wait_done4("t4 2x3 unsigned", 8'h06);
      consume4("t4");

      // Reset during the second CALC cycle
      start4(4'h6, 4'h7, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("t5 reset in_ready", 32'(w4_in_ready), 32'd1);
      check("t5 reset out_valid", 32'(w4_out_valid), 32'd0);
      check("t5 reset busy", 32'(w4_busy), 32'd0);
      check("t5 reset p", 32'(w4_p), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      start4(4'h3, 4'h5, 1'b1);
      wait_done4("t5 3x5 signed", 8'h0F);
      consume4("t5");

      // Random WIDTH=4 operations against the model
      for (int n = 0; n < 24; n++) begin
         logic [3:0] av, bv;
         logic       s;
         av = 4'($urandom); bv = 4'($urandom); s = 1'($urandom);
         start4(av, bv, s);
         wait_done4($sformatf("w4 rnd%0d a=%0h b=%0h s=%0d", n, av, bv, s),
                    8'(ref_mul(4, 32'(av), 32'(bv), s)));
         consume4($sformatf("w4 rnd%0d", n));
      end

      // Random WIDTH=8 traffic with in_valid/operand noise and consumer stalls
      for (int n = 0; n < 1500; n++) begin
         op8(n);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
